// File: rtl/pkt_buf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// pkt_buf_wr_ctrl
//   Write side of the packet buffer. Takes 9-bit words from the GMII
//   head/tail marking stage (bit8 = frame boundary, bits7:0 = byte). It
//   writes whole frames into the data FIFO and pushes one {err, len}
//   descriptor per accepted frame. Admission is decided once per frame, on
//   its head word. Frames that do not fit are dropped whole, and oversize
//   frames are cut at MAX_PKT_LEN. The block also counts received and
//   dropped frames.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_data_wr         input word valid
//   iv_data           {boundary flag, byte}
//   iv_fifo_usedw     data FIFO fill level
//   i_desc_full       descriptor FIFO full
//   ov_fifo_wdata     data FIFO write word
//   o_fifo_wr         data FIFO write enable (one pulse per word)
//   ov_desc           {err, len[10:0]}; holds its value between pulses
//   o_desc_wr         descriptor FIFO write enable (one pulse per frame)
//   ov_rx_pkt_cnt     accepted frames, wrapping
//   ov_drop_pkt_cnt   dropped frames, wrapping
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a head word; non-head words are ignored
// WRITE  | accepted frame in progress, every word goes to the FIFO
// DROP   | frame refused at its head, discard up to and including tail
// FLUSH  | frame already truncated and described, discard remainder
// ---------------------------------------------------------------------------
module pkt_buf_wr_ctrl #(
  parameter int USEDW_W      = 11,
  parameter int MAX_PKT_LEN  = 1536,
  parameter int SPACE_MARGIN = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_data_wr,
  input  logic [8:0]         iv_data,
  input  logic [USEDW_W-1:0] iv_fifo_usedw,
  input  logic               i_desc_full,
  output logic [8:0]         ov_fifo_wdata,
  output logic               o_fifo_wr,
  output logic [11:0]        ov_desc,
  output logic               o_desc_wr,
  output logic [15:0]        ov_rx_pkt_cnt,
  output logic [15:0]        ov_drop_pkt_cnt
);

  localparam int          FIFO_DEPTH = 1 << USEDW_W;
  localparam logic [31:0] NEED_WORDS = 32'(MAX_PKT_LEN + SPACE_MARGIN);
  // The descriptor carries an 11-bit length, so MAX_PKT_LEN must stay <= 2047.
  localparam logic [10:0] LEN_MAX    = 11'(MAX_PKT_LEN);
  localparam logic [10:0] LEN_LAST   = 11'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state;
  logic [10:0] len;
  logic [31:0] free_words;
  logic        admit;
  logic        bnd_word;

  // usedw never exceeds DEPTH-1, so this cannot underflow. The margin
  // covers the FIFO's usedw lagging behind our own recent writes.
  assign free_words = 32'(FIFO_DEPTH - 1) - 32'(iv_fifo_usedw);
  assign admit      = (free_words >= NEED_WORDS) && !i_desc_full;
  assign bnd_word   = i_data_wr && iv_data[8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      len             <= '0;
      ov_fifo_wdata   <= '0;
      o_fifo_wr       <= 1'b0;
      ov_desc         <= '0;
      o_desc_wr       <= 1'b0;
      ov_rx_pkt_cnt   <= '0;
      ov_drop_pkt_cnt <= '0;
    end else begin
      o_fifo_wr <= 1'b0;
      o_desc_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (bnd_word) begin
            if (admit) begin
              ov_fifo_wdata <= iv_data;
              o_fifo_wr     <= 1'b1;
              len           <= 11'd1;
              state         <= WRITE;
            end else begin
              state <= DROP;
            end
          end
        end

        WRITE: begin
          if (i_data_wr) begin
            o_fifo_wr <= 1'b1;
            if (iv_data[8]) begin
              // A tail at len == MAX-1 lands here too: exactly full, no error.
              ov_fifo_wdata <= iv_data;
              ov_desc       <= {1'b0, len + 11'd1};
              o_desc_wr     <= 1'b1;
              ov_rx_pkt_cnt <= ov_rx_pkt_cnt + 16'd1;
              len           <= '0;
              state         <= IDLE;
            end else if (len == LEN_LAST) begin
              // Last word that fits. Mark it as the boundary so the reader
              // sees a terminated frame, then describe it as truncated.
              ov_fifo_wdata <= {1'b1, iv_data[7:0]};
              ov_desc       <= {1'b1, LEN_MAX};
              o_desc_wr     <= 1'b1;
              ov_rx_pkt_cnt <= ov_rx_pkt_cnt + 16'd1;
              len           <= LEN_MAX;
              state         <= FLUSH;
            end else begin
              ov_fifo_wdata <= iv_data;
              len           <= len + 11'd1;
            end
          end
        end

        DROP: begin
          if (bnd_word) begin
            ov_drop_pkt_cnt <= ov_drop_pkt_cnt + 16'd1;
            state           <= IDLE;
          end
        end

        FLUSH: begin
          if (bnd_word) begin
            len   <= '0;
            state <= IDLE;
          end
        end

        default: begin
          len   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_buf_wr_ctrl.sv
module tb_pkt_buf_wr_ctrl;

  localparam int USEDW_W = 11;
  localparam int MAX_LEN = 1536;
  localparam int MARGIN  = 2;

  logic               i_clk;
  logic               i_rst_n;
  logic               i_data_wr;
  logic [8:0]         iv_data;
  logic [USEDW_W-1:0] iv_fifo_usedw;
  logic               i_desc_full;
  logic [8:0]         ov_fifo_wdata;
  logic               o_fifo_wr;
  logic [11:0]        ov_desc;
  logic               o_desc_wr;
  logic [15:0]        ov_rx_pkt_cnt;
  logic [15:0]        ov_drop_pkt_cnt;

  pkt_buf_wr_ctrl #(
    .USEDW_W     (USEDW_W),
    .MAX_PKT_LEN (MAX_LEN),
    .SPACE_MARGIN(MARGIN)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_data_wr      (i_data_wr),
    .iv_data        (iv_data),
    .iv_fifo_usedw  (iv_fifo_usedw),
    .i_desc_full    (i_desc_full),
    .ov_fifo_wdata  (ov_fifo_wdata),
    .o_fifo_wr      (o_fifo_wr),
    .ov_desc        (ov_desc),
    .o_desc_wr      (o_desc_wr),
    .ov_rx_pkt_cnt  (ov_rx_pkt_cnt),
    .ov_drop_pkt_cnt(ov_drop_pkt_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [8:0] w;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [11:0] d;
  } desc_t;

  int          cyc;
  int          checks;
  int          errors;
  logic [15:0] exp_rx;
  logic [15:0] exp_drop;
  logic [7:0]  fb[$];
  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  desc_t       exp_desc[$];
  desc_t       obs_desc[$];

  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Capture everything the DUT writes, with the cycle it appeared in.
  always @(negedge i_clk) begin
    if (o_fifo_wr) obs_wr.push_back('{cyc: cyc, w: ov_fifo_wdata});
    if (o_desc_wr) obs_desc.push_back('{cyc: cyc, d: ov_desc});
  end

  task automatic idle(input int n, input bit junk);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_data_wr = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      iv_data   = {1'b0, 8'($urandom)};
    end
  endtask

  task automatic fill_random(input int n);
    fb.delete();
    for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
  endtask

  // Drives the frame held in fb. The reference model is the frame-level
  // rule set: the frame is admitted or not from the head conditions. An
  // admitted frame has min(n, MAX) words written, each one cycle after it
  // was driven. The first and last written words are flagged, and one
  // descriptor is written alongside the last written word.
  // mid_mode: 0 hold head values, 1 force FIFO/desc "full", 2 random.
  task automatic send_frame(input int usedw_head, input bit full_head,
                            input int gap_at, input int gap_len, input int mid_mode);
    int n;
    int nwr;
    bit acc;
    bit trunc;
    n     = fb.size();
    acc   = ((2 ** USEDW_W - 1 - usedw_head) >= MAX_LEN + MARGIN) && !full_head;
    trunc = n > MAX_LEN;
    nwr   = acc ? (trunc ? MAX_LEN : n) : 0;
    if (acc) exp_rx++;
    else     exp_drop++;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at && i != 0) idle(gap_len, 1'b0);
      @(negedge i_clk);
      i_data_wr = 1'b1;
      iv_data   = {(i == 0) || (i == n - 1), fb[i]};
      if (i == 0) begin
        iv_fifo_usedw = USEDW_W'(usedw_head);
        i_desc_full   = full_head;
      end else if (mid_mode == 1) begin
        iv_fifo_usedw = '1;
        i_desc_full   = 1'b1;
      end else if (mid_mode == 2) begin
        iv_fifo_usedw = USEDW_W'($urandom);
        i_desc_full   = 1'($urandom_range(0, 1));
      end
      if (i < nwr) begin
        exp_wr.push_back('{cyc: cyc + 1, w: {(i == 0) || (i == nwr - 1), fb[i]}});
        if (i == nwr - 1)
          exp_desc.push_back('{cyc: cyc + 1, d: {trunc, 11'(nwr)}});
      end
    end
  endtask

  task automatic clear_queues();
    exp_wr.delete();
    obs_wr.delete();
    exp_desc.delete();
    obs_desc.delete();
  endtask

  task automatic test_reset();
    i_rst_n       = 1'b0;
    i_data_wr     = 1'b0;
    iv_data       = '0;
    iv_fifo_usedw = '0;
    i_desc_full   = 1'b0;
    exp_rx        = '0;
    exp_drop      = '0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({ov_fifo_wdata, o_fifo_wr, ov_desc, o_desc_wr, ov_rx_pkt_cnt, ov_drop_pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wdata=%h wr=%b desc=%h dwr=%b rx=%h drop=%h, required all 0",
               ov_fifo_wdata, o_fifo_wr, ov_desc, o_desc_wr, ov_rx_pkt_cnt, ov_drop_pkt_cnt);
    end
    i_rst_n = 1'b1;
    idle(3, 1'b1);
    checks++;
    if (o_fifo_wr !== 1'b0 || o_desc_wr !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got wr=%b dwr=%b, required 0 0", o_fifo_wr, o_desc_wr);
    end
    clear_queues();
  endtask

  task automatic test_basic();
    fill_random(64);
    fb[0]  = 8'hAA;
    fb[63] = 8'h55;
    send_frame(0, 1'b0, 0, 0, 0);
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL basic_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 1 || obs_desc[0].d !== 12'h040 || obs_desc[0].cyc != exp_desc[0].cyc) begin
      errors++;
      $display("FAIL basic_desc: got count=%0d first=%h, required one 040@%0d",
               obs_desc.size(), obs_desc.size() ? obs_desc[0].d : 12'h0, exp_desc[0].cyc);
    end
    checks++;
    if (ov_desc !== 12'h040) begin
      errors++;
      $display("FAIL basic_desc_hold: got %h, required 040", ov_desc);
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL basic_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    clear_queues();
  endtask

  task automatic test_admission();
    fill_random(20);
    send_frame(2047 - 1537, 1'b0, 0, 0, 0);  // free 1537: one short
    idle(2, 1'b0);
    checks++;
    if (obs_wr.size() != 0 || obs_desc.size() != 0 || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL admit_drop: got writes=%0d descs=%0d drop=%0d, required 0 0 %0d",
               obs_wr.size(), obs_desc.size(), ov_drop_pkt_cnt, exp_drop);
    end
    fill_random(20);
    send_frame(2047 - 1538, 1'b0, 0, 0, 0);  // free 1538: exactly enough
    fill_random(33);
    send_frame(0, 1'b0, 0, 0, 0);
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL admit_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL admit_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 2 || obs_desc[0].d !== 12'h014 || obs_desc[1].d !== 12'h021) begin
      errors++;
      $display("FAIL admit_desc: got count=%0d, required 014 then 021", obs_desc.size());
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL admit_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    clear_queues();
  endtask

  task automatic test_desc_full();
    fill_random(30);
    send_frame(0, 1'b1, 0, 0, 0);
    fill_random(45);
    send_frame(0, 1'b0, 10, 2, 1);  // FIFO/desc go "full" right after head
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL dfull_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL dfull_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 1 || obs_desc[0].d !== 12'h02D || obs_desc[0].cyc != exp_desc[0].cyc) begin
      errors++;
      $display("FAIL dfull_desc: got count=%0d, required one 02D@%0d", obs_desc.size(), exp_desc[0].cyc);
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL dfull_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    i_desc_full   = 1'b0;
    iv_fifo_usedw = '0;
    clear_queues();
  endtask

  task automatic test_truncate();
    fill_random(2000);
    send_frame(0, 1'b0, 0, 0, 0);
    fill_random(MAX_LEN);       // tail lands exactly at the limit
    send_frame(0, 1'b0, 0, 0, 0);
    fill_random(MAX_LEN + 1);   // one over: only the tail is discarded
    send_frame(0, 1'b0, 0, 0, 0);
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL trunc_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL trunc_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 3 || obs_desc[0].d !== 12'hE00 || obs_desc[1].d !== 12'h600 ||
        obs_desc[2].d !== 12'hE00) begin
      errors++;
      $display("FAIL trunc_desc: got count=%0d, required E00 600 E00", obs_desc.size());
    end
    for (int i = 0; i < exp_desc.size() && i < obs_desc.size(); i++) begin
      checks++;
      if (obs_desc[i].cyc != exp_desc[i].cyc) begin
        errors++;
        $display("FAIL trunc_desc_cyc[%0d]: got %0d, required %0d", i, obs_desc[i].cyc, exp_desc[i].cyc);
      end
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL trunc_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    fill_random(60);
    send_frame(0, 1'b0, 20, 5, 0);
    fill_random(60);
    send_frame(0, 1'b0, 0, 0, 0);
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != 120 || exp_wr.size() != 120) begin
      errors++;
      $display("FAIL b2b_wr_count: got %0d, required 120", obs_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 2 || obs_desc[0].d !== 12'h03C || obs_desc[1].d !== 12'h03C ||
        obs_desc[1].cyc != exp_desc[1].cyc) begin
      errors++;
      $display("FAIL b2b_desc: got count=%0d, required two 03C", obs_desc.size());
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL b2b_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    clear_queues();
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 16; f++) begin
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1500, 1700) : $urandom_range(2, 150);
      fill_random(n);
      send_frame($urandom_range(0, 700), 1'($urandom_range(0, 4) == 0),
                 $urandom_range(1, n - 1), $urandom_range(0, 4), 2);
      idle($urandom_range(0, 3), 1'b1);
    end
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL rand_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != exp_desc.size()) begin
      errors++;
      $display("FAIL rand_desc_count: got %0d, required %0d", obs_desc.size(), exp_desc.size());
    end
    for (int i = 0; i < exp_desc.size() && i < obs_desc.size(); i++) begin
      checks++;
      if (obs_desc[i].d !== exp_desc[i].d || obs_desc[i].cyc != exp_desc[i].cyc) begin
        errors++;
        $display("FAIL rand_desc[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_desc[i].d, obs_desc[i].cyc, exp_desc[i].d, exp_desc[i].cyc);
      end
    end
    checks++;
    if (ov_rx_pkt_cnt !== exp_rx || ov_drop_pkt_cnt !== exp_drop) begin
      errors++;
      $display("FAIL rand_counts: got rx=%0d drop=%0d, required rx=%0d drop=%0d",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt, exp_rx, exp_drop);
    end
    i_desc_full   = 1'b0;
    iv_fifo_usedw = '0;
    clear_queues();
  endtask

  task automatic test_reset_mid_frame();
    fill_random(40);
    iv_fifo_usedw = '0;
    i_desc_full   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      i_data_wr = 1'b1;
      iv_data   = {i == 0, fb[i]};
    end
    @(posedge i_clk);
    #2;
    i_rst_n   = 1'b0;
    i_data_wr = 1'b0;
    #1;
    checks++;
    if ({ov_fifo_wdata, o_fifo_wr, ov_desc, o_desc_wr, ov_rx_pkt_cnt, ov_drop_pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got wdata=%h wr=%b desc=%h dwr=%b rx=%h drop=%h, required all 0",
               ov_fifo_wdata, o_fifo_wr, ov_desc, o_desc_wr, ov_rx_pkt_cnt, ov_drop_pkt_cnt);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n  = 1'b1;
    exp_rx   = '0;
    exp_drop = '0;
    clear_queues();
    fill_random(50);
    send_frame(0, 1'b0, 0, 0, 0);
    idle(3, 1'b0);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL rst_wr_count: got %0d, required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i].w !== exp_wr[i].w || obs_wr[i].cyc != exp_wr[i].cyc) begin
        errors++;
        $display("FAIL rst_word[%0d]: got %h@%0d, required %h@%0d",
                 i, obs_wr[i].w, obs_wr[i].cyc, exp_wr[i].w, exp_wr[i].cyc);
      end
    end
    checks++;
    if (obs_desc.size() != 1 || obs_desc[0].d !== 12'h032) begin
      errors++;
      $display("FAIL rst_desc: got count=%0d, required one 032", obs_desc.size());
    end
    checks++;
    if (ov_rx_pkt_cnt !== 16'd1 || ov_drop_pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_counts: got rx=%0d drop=%0d, required rx=1 drop=0",
               ov_rx_pkt_cnt, ov_drop_pkt_cnt);
    end
    clear_queues();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_admission();
    test_desc_full();
    test_truncate();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
